tanh4_share_arbiter: RTL and testbench

- Shares one 4-bit approximate tanh core between NUM_REQ requesters.
- Round-robin arbitration with a valid/ready handshake on each requester port.
- Two-stage pipeline (operand register, then result register); every result carries the ID of the requester that issued it.
- Sits between the per-lane activation requesters of a small NN datapath and the single shared activation unit.

---
 rtl/tanh4_share_arbiter.sv | 120 ++++++++++++
 tb/tb_tanh4_share_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tanh4_share_arbiter.sv
// tanh4_share_arbiter
//   Shares one 4-bit approximate tanh core between NUM_REQ requesters.
//   Round-robin grant into a two-stage pipeline: S1 holds the granted
//   operand and its ID, S2 holds the core result and ID and drives rsp_*.
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   req_valid    per-requester operand valid
//   req_data     per-requester 4-bit operand, requester i in [4i+3:4i]
//   req_ready    one-hot (or zero) accept, combinational
//   rsp_valid    result valid (S2 occupied)
//   rsp_data     tanh approximation of the operand
//   rsp_id       requester that issued the result
//   rsp_ready    consumer accepts the result
//   busy         either pipeline stage holds data
module tanh4_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [4*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   rsp_valid,
    output logic [3:0]             rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    input  logic                   rsp_ready,
    output logic                   busy
);

    // Bit-exact approximate tanh on a 4-bit operand.
    function automatic logic [3:0] tanh4(input logic [3:0] x);
        logic [3:0] y;
        y[0] = x[0];
        y[1] = x[0];
        y[2] = x[1] & ((x[0] ^ x[1]) | x[2]);
        y[3] = x[1] ^ ~((x[0] ^ x[1]) | x[3]);
        return y;
    endfunction

    logic [ID_W-1:0] ptr;
    logic            s1_valid;
    logic [3:0]      s1_data;
    logic [ID_W-1:0] s1_id;

    logic            s2_adv;
    logic            s1_adv;
    logic            grant_any;
    logic [ID_W-1:0] grant_id;
    logic [3:0]      grant_data;
    logic [ID_W:0]   idx;
    logic            take;
    logic [ID_W-1:0] ptr_next;

    assign s2_adv = !rsp_valid | rsp_ready;
    assign s1_adv = !s1_valid | s2_adv;
    assign take   = s1_adv & grant_any;
    assign busy   = s1_valid | rsp_valid;

    // Scan from ptr upward with wrap; idx carries one extra bit so the
    // modulo works for non-power-of-two NUM_REQ.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NUM_REQ))
                idx = idx - (ID_W+1)'(NUM_REQ);
            if (!grant_any && req_valid[idx[ID_W-1:0]]) begin
                grant_any = 1'b1;
                grant_id  = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        grant_data = '0;
        req_ready  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                grant_data   = req_data[4*i +: 4];
                req_ready[i] = take;
            end
        end
    end

    assign ptr_next = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            if (s2_adv) begin
                rsp_valid <= s1_valid;
                // Only load payload from a live S1 so idle outputs stay quiet.
                if (s1_valid) begin
                    rsp_data <= tanh4(s1_data);
                    rsp_id   <= s1_id;
                end
            end
            if (s1_adv) begin
                s1_valid <= take;
                if (take) begin
                    s1_data <= grant_data;
                    s1_id   <= grant_id;
                    ptr     <= ptr_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_tanh4_share_arbiter.sv
module tb_tanh4_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [3:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic        rsp_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Hand-computed core results for operands 0..15.
    logic [3:0] tbl [16] = '{4'h8, 4'h3, 4'hC, 4'h3, 4'h8, 4'h3, 4'hC, 4'h7,
                             4'h0, 4'h3, 4'hC, 4'hB, 4'h0, 4'h3, 4'hC, 4'hF};
    // Results of the fixed per-requester operands {1,2,7,B}.
    logic [3:0] rr_res [4] = '{4'h3, 4'hC, 4'h7, 4'hB};

    tanh4_share_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        rst_n = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if ({rsp_data, rsp_id} !== 6'h0) begin errors++; $display("FAIL reset_rsp got %h/%0d exp 0/0", rsp_data, rsp_id); end
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        req_valid = 4'b0100; req_data = '0; req_data[11:8] = 4'h6; rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b exp 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_s1 got v%b b%b exp v0 b1", rsp_valid, busy); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 4'hC || rsp_id !== 2'd2)
            begin errors++; $display("FAIL single_rsp got v%b %h id%0d exp v1 c id2", rsp_valid, rsp_data, rsp_id); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got b%b v%b exp 0 0", busy, rsp_valid); end
    endtask

    task automatic test_truth_table();
        rsp_ready = 1'b1;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_data !== tbl[c-2] || rsp_id !== 2'd0)
                    begin errors++; $display("FAIL truth_x%0d got v%b %h id%0d exp v1 %h id0", c-2, rsp_valid, rsp_data, rsp_id, tbl[c-2]); end
            end
            if (c < 16) begin
                req_valid = 4'b0001; req_data = '0; req_data[3:0] = 4'(c);
                #1;
                checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL truth_ready%0d got %b exp 0001", c, req_ready); end
            end else begin
                req_valid = '0;
            end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL truth_drain got %b exp 0", busy); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [9] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                  4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [1:0] exp_id [9] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        rsp_ready = 1'b1;
        req_data = {4'hB, 4'h7, 4'h2, 4'h1};
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== exp_id[c-2] || rsp_data !== rr_res[exp_id[c-2]])
                    begin errors++; $display("FAIL rr_rsp%0d got v%b id%0d %h exp v1 id%0d %h", c-2, rsp_valid, rsp_id, rsp_data, exp_id[c-2], rr_res[exp_id[c-2]]); end
            end
            // First cycle: requester 3 alone, exercising the ptr wrap to 0.
            if (c == 0) req_valid = 4'b1000;
            else if (c <= 8) req_valid = 4'b1111;
            else req_valid = '0;
            if (c <= 8) begin
                #1;
                checks++; if (req_ready !== exp_g[c]) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", c, req_ready, exp_g[c]); end
            end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_drain got %b exp 0", busy); end
    endtask

    task automatic test_backpressure();
        req_data = {4'hB, 4'h7, 4'h2, 4'h1};
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_grant0 got %b exp 0001", req_ready); end
        @(negedge clk);
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant1 got %b exp 0010", req_ready); end
        for (int c = 2; c < 5; c++) begin
            @(negedge clk);
            #1;
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall%0d got %b exp 0000", c, req_ready); end
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== 4'h3 || rsp_id !== 2'd0 || busy !== 1'b1)
                begin errors++; $display("FAIL bp_hold%0d got v%b %h id%0d b%b exp v1 3 id0 b1", c, rsp_valid, rsp_data, rsp_id, busy); end
        end
        // Release with both stages full: drain, shift and new grant together.
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_grant got %b exp 0100", req_ready); end
        checks++; if (rsp_id !== 2'd0 || rsp_data !== 4'h3) begin errors++; $display("FAIL bp_release_rsp got id%0d %h exp id0 3", rsp_id, rsp_data); end
        @(negedge clk);
        req_valid = '0;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 4'hC)
            begin errors++; $display("FAIL bp_drain1 got v%b id%0d %h exp v1 id1 c", rsp_valid, rsp_id, rsp_data); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 4'h7)
            begin errors++; $display("FAIL bp_drain2 got v%b id%0d %h exp v1 id2 7", rsp_valid, rsp_id, rsp_data); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_empty got v%b b%b exp 0 0", rsp_valid, busy); end
    endtask

    task automatic test_ptr_skip();
        rsp_ready = 1'b1;
        req_data = {4'hB, 4'h7, 4'h2, 4'h1};
        @(negedge clk);
        req_valid = 4'b0001;  // grant to 0 leaves ptr = 1
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL skip_setup got %b exp 0001", req_ready); end
        @(negedge clk);
        req_valid = 4'b1001;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL skip_grant3 got %b exp 1000", req_ready); end
        @(negedge clk);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL skip_grant0 got %b exp 0001", req_ready); end
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin errors++; $display("FAIL skip_rsp0 got v%b id%0d exp v1 id0", rsp_valid, rsp_id); end
        @(negedge clk);
        req_valid = '0;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 4'hB)
            begin errors++; $display("FAIL skip_rsp3 got v%b id%0d %h exp v1 id3 b", rsp_valid, rsp_id, rsp_data); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin errors++; $display("FAIL skip_rsp0b got v%b id%0d exp v1 id0", rsp_valid, rsp_id); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL skip_drain got %b exp 0", busy); end
    endtask

    task automatic test_async_reset();
        req_data = {4'hB, 4'h7, 4'h2, 4'h1};
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL ar_grant1 got %b exp 0010", req_ready); end
        @(negedge clk);
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL ar_grant2 got %b exp 0100", req_ready); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || busy !== 1'b1 || rsp_id !== 2'd1)
            begin errors++; $display("FAIL ar_full got v%b b%b id%0d exp v1 b1 id1", rsp_valid, busy, rsp_id); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ar_clear got v%b b%b exp 0 0", rsp_valid, busy); end
        checks++; if (rsp_id !== 2'd0 || rsp_data !== 4'h0) begin errors++; $display("FAIL ar_payload got id%0d %h exp id0 0", rsp_id, rsp_data); end
        @(negedge clk);
        rst_n = 1'b1; rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL ar_prio got %b exp 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 4'h3)
            begin errors++; $display("FAIL ar_after got v%b id%0d %h exp v1 id0 3", rsp_valid, rsp_id, rsp_data); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_truth_table();
        test_round_robin();
        test_backpressure();
        test_ptr_skip();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
